// File: rtl/axi_lite_sram_pkg.sv
// rtl/axi_lite_sram_pkg.sv - shared AXI-Lite response codes and responder FSM states
package axi_lite_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Latency counter width; covers latencies 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_RESP
  } state_e;

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - word array with byte-lane write enables and combinational read
module sram_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Commit only the enabled byte lanes; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_lite_sram.sv
// rtl/axi_lite_sram.sv - AXI4-Lite SRAM responder with programmable read/write latency
module axi_lite_sram
  import axi_lite_sram_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               bvalid_q, bvalid_d;

  logic [31:0]        dec_off;
  logic               dec_hit;
  logic [AW-1:0]      dec_idx;
  logic [31:0]        mem_rdata;
  logic               mem_we;
  logic               wr_hs;

  // The array is only touched in the WAIT states, so decode always works on the latched address.
  assign dec_off = addr_q - BASE;
  assign dec_hit = (addr_q >= BASE) && (dec_off < SPAN);
  assign dec_idx = dec_off[AW+1:2];

  // A read pending in IDLE blocks the write; AW and W are only ever taken together.
  assign wr_hs   = (state_q == IDLE) && !arvalid && awvalid && wvalid;
  assign arready = (state_q == IDLE);
  assign awready = wr_hs;
  assign wready  = wr_hs;

  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rvalid = rvalid_q;
  assign bresp  = bresp_q;
  assign bvalid = bvalid_q;

  sram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .wstrb (wstrb_q),
    .waddr (dec_idx),
    .wdata (wdata_q),
    .raddr (dec_idx),
    .rdata (mem_rdata)
  );

  // Next-state, latency countdown and response generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rvalid_d = rvalid_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arvalid) begin
          addr_d  = araddr;
          cnt_d   = CNT_W'(READ_LAT - 1);
          state_d = RD_WAIT;
        end else if (wr_hs) begin
          addr_d  = awaddr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          cnt_d   = CNT_W'(WRITE_LAT - 1);
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d  = dec_hit ? mem_rdata : 32'h0;
          rresp_d  = dec_hit ? RESP_OKAY : RESP_SLVERR;
          rvalid_d = 1'b1;
          state_d  = RD_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          mem_we   = dec_hit;
          bresp_d  = dec_hit ? RESP_OKAY : RESP_SLVERR;
          bvalid_d = 1'b1;
          state_d  = WR_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rvalid_q <= rvalid_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// tb/tb_axi_lite_sram.sv - scoreboard bench for the AXI-Lite SRAM responder
module tb_axi_lite_sram;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int          DEPTH     = 4096;
  localparam int          READ_LAT  = 2;
  localparam int          WRITE_LAT = 2;
  localparam int          BUDGET    = 200;
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  always #5 clk = ~clk;

  axi_lite_sram #(
    .BASE      (BASE),
    .DEPTH     (DEPTH),
    .READ_LAT  (READ_LAT),
    .WRITE_LAT (WRITE_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t     rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model [int unsigned];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          ar_cyc = 0;
  int          aw_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [63:0] av, lo, hi;
    av = {32'd0, a};
    lo = {32'd0, BASE};
    hi = lo + 64'(4 * DEPTH);
    return (av >= lo) && (av < hi);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int unsigned key = int'(a >> 2);
    return model.exists(key) ? model[key] : 32'h0;
  endfunction

  // Monitor: owns the cycle count, checks latency and every cycle a response is presented.
  initial begin : monitor
    logic prev_rv;
    logic prev_bv;
    prev_rv = 1'b0;
    prev_bv = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_rv = 1'b0;
        prev_bv = 1'b0;
        continue;
      end
      if (arvalid && arready) ar_cyc = cyc;
      if (awvalid && awready && wvalid && wready) aw_cyc = cyc;
      if (rvalid) begin
        if (!prev_rv) chk("rd_latency", 32'(cyc - ar_cyc), 32'(READ_LAT + 1));
        if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else begin
          chk("rdata", rdata, rq[0].data);
          chk("rresp", 32'(rresp), 32'(rq[0].resp));
          if (rready) void'(rq.pop_front());
        end
      end
      if (bvalid) begin
        if (!prev_bv) chk("wr_latency", 32'(cyc - aw_cyc), 32'(WRITE_LAT + 1));
        if (bq.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          chk("bresp", 32'(bresp), 32'(bq[0]));
          if (bready) void'(bq.pop_front());
        end
      end
      prev_rv = rvalid;
      prev_bv = bvalid;
    end
  end

  task automatic do_read(input logic [31:0] a, input int hold);
    bit      ok = 1'b0;
    rd_exp_t e;
    @(posedge clk); #2;
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("ar_timeout", 32'd0, 32'd1); arvalid = 1'b0; return; end
    e.data = in_rng(a) ? model_rd(a) : 32'h0;
    e.resp = in_rng(a) ? OKAY : SLVERR;
    rq.push_back(e);
    @(posedge clk); #2;
    arvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("r_timeout", 32'd0, 32'd1); return; end
    repeat (hold) @(negedge clk);
    @(posedge clk); #2;
    rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold);
    bit          ok = 1'b0;
    int unsigned key;
    logic [31:0] w;
    @(posedge clk); #2;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("aw_timeout", 32'd0, 32'd1);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      return;
    end
    if (in_rng(a)) begin
      key = int'(a >> 2);
      w   = model_rd(a);
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      model[key] = w;
    end
    bq.push_back(in_rng(a) ? OKAY : SLVERR);
    @(posedge clk); #2;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("b_timeout", 32'd0, 32'd1); return; end
    repeat (hold) @(negedge clk);
    @(posedge clk); #2;
    bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #2;
    bready = 1'b0;
  endtask

  logic [31:0] pool [8] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0010, 32'h8000_0100,
                            32'h8000_1000, 32'h8000_3FFC, 32'h8000_2A40, 32'h8000_0FF8};
  logic [31:0] oor  [4] = '{32'h7FFF_FFFC, 32'h8000_4000, 32'h0000_0000, 32'hFFFF_FFFC};

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit ok;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    chk("reset_arready", 32'(arready), 32'd1);
    chk("reset_awready", 32'(awready), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_bvalid", 32'(bvalid), 32'd0);

    for (int i = 0; i < 8; i++) do_write(pool[i], $urandom, 4'hF, 0);

    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    do_read(32'h8000_0010, 0);

    do_write(32'h8000_0010, 32'h0000_00AA, 4'b0001, 1);
    do_read(32'h8000_0010, 0);

    fork
      do_read(32'h8000_0010, 5);
      do_write(32'h8000_0010, 32'h1234_5678, 4'b1100, 0);
    join
    chk("arb_read_first", 32'(aw_cyc > ar_cyc), 32'd1);
    do_read(32'h8000_0010, 0);

    do_write(32'h8000_0004, 32'hFFFF_FFFF, 4'b0000, 0);
    do_read(32'h8000_0004, 0);

    do_read(32'h7FFF_FFFC, 1);
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2);
    do_read(32'h8000_0000, 0);
    do_read(32'h8000_3FFC, 0);

    @(posedge clk); #2;
    awaddr  = 32'h8000_0100;
    wdata   = 32'hCAFE_F00D;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    chk("rst_aw_handshake", 32'(ok), 32'd1);
    @(posedge clk); #2;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_bvalid", 32'(bvalid), 32'd0);
    chk("rst_mid_arready", 32'(arready), 32'd1);
    do_read(32'h8000_0100, 0);

    for (int it = 0; it < 40; it++) begin
      logic [31:0] a;
      int          op;
      op = $urandom_range(0, 2);
      a  = ($urandom_range(0, 5) == 0) ? oor[$urandom_range(0, 3)] : pool[$urandom_range(0, 7)];
      case (op)
        0: do_read(a, $urandom_range(0, 3));
        1: do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        default: fork
          do_read(a, $urandom_range(0, 3));
          do_write(pool[$urandom_range(0, 7)], $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3));
        join
      endcase
    end

    repeat (5) @(negedge clk);
    chk("rd_queue_drained", 32'(rq.size()), 32'd0);
    chk("wr_queue_drained", 32'(bq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
